// File: rtl/seq16_en_counter.sv
// seq16_en_counter: golden 16-bit up-counter with enable and active-low clear.
// The counter is mapped onto a 24-bit user I/O bank. Control bits come in on
// io_in, the count goes out on io_out, and io_oeb fixes each pad's direction
// (low half driven, high half input). A fabric bitstream with the same
// function is compared against this block every cycle, so io_out comes
// straight from the count register and io_oeb is a constant.

// Assertion checker for the counter. It is instantiated by the top module.
module seq16_en_counter_chk #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned IO_WIDTH = 24,
  parameter int unsigned EN_BIT   = 23,
  parameter int unsigned CLRN_BIT = 22
) (
  input logic                clk,
  input logic                rst,
  input logic [IO_WIDTH-1:0] io_out,
  input logic [IO_WIDTH-1:0] io_oeb
);

  localparam logic [IO_WIDTH-1:0] OEB_EXP = {{(IO_WIDTH-WIDTH){1'b1}}, {WIDTH{1'b0}}};

  // The counter must fit inside the bank, leaving room for the control pads.
  a_width_fits: assert property (@(posedge clk) (WIDTH < IO_WIDTH));

  // The enable pad is an input pad above the counter field.
  a_en_bit_range: assert property (@(posedge clk) ((EN_BIT >= WIDTH) && (EN_BIT < IO_WIDTH)));

  // The clear pad is an input pad above the counter field.
  a_clrn_bit_range: assert property (@(posedge clk) ((CLRN_BIT >= WIDTH) && (CLRN_BIT < IO_WIDTH)));

  // The enable and clear controls must sit on distinct pads.
  a_ctrl_distinct: assert property (@(posedge clk) (EN_BIT != CLRN_BIT));

  // Pad directions never change.
  a_oeb_const: assert property (@(posedge clk) (io_oeb == OEB_EXP));

  // The pads above the counter field never drive a one.
  a_out_upper_zero: assert property (@(posedge clk) (io_out[IO_WIDTH-1:WIDTH] == '0));

  // The count is zero on the edge after a reset.
  a_rst_zero: assert property (@(posedge clk) rst |=> (io_out[WIDTH-1:0] == '0));

endmodule

// Top-level counter mapped onto the user I/O bank.
module seq16_en_counter #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned IO_WIDTH = 24,
  parameter int unsigned EN_BIT   = 23,
  parameter int unsigned CLRN_BIT = 22
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IO_WIDTH-1:0] io_in,
  output logic [IO_WIDTH-1:0] io_out,
  output logic [IO_WIDTH-1:0] io_oeb
);

  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic             en_s;
  logic             clrn_s;
  logic             unused_io_in_s;

  // io_in is synchronous to clk, so the control pads are used without a synchronizer.
  assign en_s   = io_in[EN_BIT];
  assign clrn_s = io_in[CLRN_BIT];

  // The remaining pad inputs have no function in this design.
  assign unused_io_in_s = ^io_in;

  // Next count: clear beats enable, and increment wraps modulo 2^WIDTH.
  always_comb begin
    cnt_d = cnt_q;
    case ({clrn_s, en_s})
      2'b00:   cnt_d = CNT_ZERO;
      2'b01:   cnt_d = CNT_ZERO;
      2'b10:   cnt_d = cnt_q;
      2'b11:   cnt_d = cnt_q + CNT_ONE;
      default: cnt_d = CNT_ZERO;
    endcase
  end

  // Count register with synchronous reset, which takes priority over everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Pad mapping: the count drives the low pads, and the upper pads are inputs that drive zero.
  for (genvar i = 0; i < IO_WIDTH; i++) begin : g_io_map
    if (i < WIDTH) begin : g_out_pad
      assign io_out[i] = cnt_q[i];
      assign io_oeb[i] = 1'b0;
    end else begin : g_in_pad
      assign io_out[i] = 1'b0;
      assign io_oeb[i] = 1'b1;
    end
  end

  seq16_en_counter_chk #(
    .WIDTH    (WIDTH),
    .IO_WIDTH (IO_WIDTH),
    .EN_BIT   (EN_BIT),
    .CLRN_BIT (CLRN_BIT)
  ) u_chk (
    .clk    (clk),
    .rst    (rst),
    .io_out (io_out),
    .io_oeb (io_oeb)
  );

endmodule

// File: tb/tb_seq16_en_counter.sv
// Testbench for seq16_en_counter. It applies table-driven vectors, then runs
// hand-written reset, clear and wrap sequences.
module tb_seq16_en_counter;

  localparam logic [23:0] OEB_EXP = 24'hFF0000;
  localparam logic [23:0] IN_CLR  = 24'h800000;
  localparam logic [23:0] IN_RUN  = 24'hC00000;
  localparam logic [23:0] IN_HOLD = 24'h400000;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] io_in;
  logic [23:0] io_out;
  logic [23:0] io_oeb;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rst;
    logic [23:0] io_in;
    logic [23:0] exp_out;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  seq16_en_counter dut (
    .clk    (clk),
    .rst    (rst),
    .io_in  (io_in),
    .io_out (io_out),
    .io_oeb (io_oeb)
  );

  task automatic add(input logic r, input logic [23:0] i, input logic [23:0] e);
    vec_t v;
    v.rst = r;
    v.io_in = i;
    v.exp_out = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %06h expected %06h", name, act, exp);
    end
  endtask

  // Drive the inputs, take one rising edge, then check the outputs at the following negedge.
  task automatic step(input logic r, input logic [23:0] i, input logic [23:0] e, input string name);
    rst = r;
    io_in = i;
    @(posedge clk);
    @(negedge clk);
    check({name, ".out"}, io_out, e);
    check({name, ".oeb"}, io_oeb, OEB_EXP);
  endtask

  // Drive the inputs and take one rising edge without checking.
  task automatic step_quiet(input logic r, input logic [23:0] i);
    rst = r;
    io_in = i;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] exp;
    rst = 1'b0;
    io_in = 24'h000000;
    #1;
    check("oeb_before_clock", io_oeb, OEB_EXP);

    // Idle: io_in = 0 clears the count, even without a reset.
    for (int k = 0; k < 10; k++) add(1'b0, 24'h000000, 24'h000000);
    // Enable alone, with clear_n low, keeps the count at zero.
    for (int k = 0; k < 5; k++) add(1'b0, IN_CLR, 24'h000000);
    // Count from 1 up to 0x64.
    for (int k = 1; k <= 100; k++) add(1'b0, IN_RUN, 24'(k));
    // Hold for 7 cycles.
    for (int k = 0; k < 7; k++) add(1'b0, IN_HOLD, 24'h000064);
    // Resume counting.
    for (int k = 0; k < 5; k++) add(1'b0, IN_RUN, 24'h000065 + 24'(k));
    // The unused pad inputs are ignored.
    add(1'b0, 24'hC0FFFF, 24'h00006A);
    add(1'b0, 24'h7FFFFF, 24'h00006A);
    add(1'b0, 24'hBFFFFF, 24'h000000);
    add(1'b0, 24'hC12345, 24'h000001);

    foreach (vecs[n]) begin
      step(vecs[n].rst, vecs[n].io_in, vecs[n].exp_out, $sformatf("vec%0d", n));
    end

    // Reset priority: reset at 0x30 with enable and clear_n both high.
    exp = 24'h000001;
    while (exp != 24'h000030) begin
      exp = exp + 24'h000001;
      step_quiet(1'b0, IN_RUN);
    end
    check("reach_0x30", io_out, 24'h000030);
    step(1'b1, IN_RUN, 24'h000000, "rst_prio");
    step(1'b0, IN_RUN, 24'h000001, "rst_resume");

    // Clear in the middle of a count.
    exp = 24'h000001;
    while (exp != 24'h000123) begin
      exp = exp + 24'h000001;
      step_quiet(1'b0, IN_RUN);
    end
    check("reach_0x123", io_out, 24'h000123);
    step(1'b0, IN_CLR, 24'h000000, "clr_mid");
    step(1'b0, IN_RUN, 24'h000001, "clr_resume");

    // Wrap from 0xFFFF to zero.
    exp = 24'h000001;
    while (exp != 24'h00FFFF) begin
      exp = exp + 24'h000001;
      step_quiet(1'b0, IN_RUN);
    end
    check("reach_0xFFFF", io_out, 24'h00FFFF);
    step(1'b0, IN_RUN, 24'h000000, "wrap");
    step(1'b0, IN_RUN, 24'h000001, "wrap_next");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
